// File: rtl/pcpi_pkg.sv
// Shared types and constants for the PCPI issue block: FSM states, opcode fields and
// the default timeout.
package pcpi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } pcpi_state_e;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] Funct7Muldiv = 7'b0000001;

  localparam int unsigned TimeoutDefault = 16;

  function automatic logic is_muldiv(logic [31:0] insn);
    return (insn[6:0] == OpcodeOp) && (insn[31:25] == Funct7Muldiv);
  endfunction

endpackage

// File: rtl/pcpi_timer.sv
// Saturating 8-bit idle counter for a PCPI request; expired_o flags the last allowed
// non-waiting cycle.
module pcpi_timer #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic wait_i,
  output logic expired_o
);

  localparam logic [7:0] Limit = 8'(Timeout - 1);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (wait_i) begin
        cnt_d = '0;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && !wait_i && (cnt_q == Limit);

endmodule

// File: rtl/pcpi_issue.sv
// Issues one core instruction to PCPI co-processors and returns the response.
// Define PCPI_TIMEOUT_EN to flag unclaimed instructions as illegal after a timeout.
module pcpi_issue
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  pcpi_state_e state_d, state_q;
  logic        timeout_hit;

  logic [31:0] insn_q, rs1_q, rs2_q;
  logic        rsp_wr_q;
  logic [31:0] rsp_rd_q;

`ifdef PCPI_TIMEOUT_EN
  logic rsp_illegal_q;

  pcpi_timer #(
    .Timeout (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (state_q != StIssue),
    .enable_i  (state_q == StIssue),
    .wait_i    (pcpi_wait),
    .expired_o (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_illegal_q <= 1'b0;
    end else if (state_q == StIssue) begin
      if (pcpi_ready) begin
        rsp_illegal_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_illegal_q <= 1'b1;
      end
    end
  end

  assign rsp_illegal = rsp_illegal_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  logic unused_wait;

  assign unused_wait = pcpi_wait;
  assign timeout_hit = 1'b0;
  assign rsp_illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StIssue;
      StIssue: if (pcpi_ready || timeout_hit) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands are held from acceptance until the next accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if ((state_q == StIdle) && req_valid) begin
      insn_q <= req_insn;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
    end
  end

  // A claimed result wins over a timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_wr_q <= 1'b0;
      rsp_rd_q <= '0;
    end else if (state_q == StIssue) begin
      if (pcpi_ready) begin
        rsp_wr_q <= pcpi_wr;
        rsp_rd_q <= pcpi_rd;
      end else if (timeout_hit) begin
        rsp_wr_q <= 1'b0;
        rsp_rd_q <= '0;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign pcpi_valid = (state_q == StIssue);
  assign rsp_valid  = (state_q == StResp);
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_rd     = rsp_rd_q;

endmodule

// File: tb/tb_pcpi_issue.sv
// Directed bench for pcpi_issue; timeout expectations follow PCPI_TIMEOUT_EN.
module tb_pcpi_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        rsp_illegal;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcpi_issue #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_insn    (req_insn),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_wr      (rsp_wr),
    .rsp_rd      (rsp_rd),
    .rsp_illegal (rsp_illegal),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a request at the next edge; returns in the first ISSUE cycle.
  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    step();
    req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    logic [31:0] held_rd;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
    check("rst_rsp_wr", 32'(rsp_wr), 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("rst_rsp_rd", rsp_rd, 32'd0);
    check("rst_pcpi_insn", pcpi_insn, 32'd0);
    check("rst_pcpi_rs1", pcpi_rs1, 32'd0);

    // Responder signals ignored in IDLE
    pcpi_ready = 1'b1;
    pcpi_rd    = 32'hDEAD_BEEF;
    step();
    pcpi_ready = 1'b0;
    check("idle_ignore_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_ignore_rsp_rd", rsp_rd, 32'd0);

    // MUL 7*6 with wait then ready
    issue(32'h02A3_0333, 32'd7, 32'd6);
    check("mul_pcpi_valid", 32'(pcpi_valid), 32'd1);
    check("mul_req_ready", 32'(req_ready), 32'd0);
    check("mul_pcpi_insn", pcpi_insn, 32'h02A3_0333);
    check("mul_pcpi_rs1", pcpi_rs1, 32'd7);
    check("mul_pcpi_rs2", pcpi_rs2, 32'd6);
    step();
    step();
    pcpi_wait = 1'b1;
    step();
    step();
    step();
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'd42;
    check("mul_no_early_rsp", 32'(rsp_valid), 32'd0);
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    check("mul_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mul_pcpi_valid_low", 32'(pcpi_valid), 32'd0);
    check("mul_rsp_rd", rsp_rd, 32'd42);
    check("mul_rsp_wr", 32'(rsp_wr), 32'd1);
    check("mul_rsp_illegal", 32'(rsp_illegal), 32'd0);
    handshake("mul");

    // No responder: illegal after the timeout, or indefinite wait without it
    issue(32'h0000_0033, 32'd1, 32'd2);
    for (int i = 0; i < 15; i++) step();
    check("to_not_yet", 32'(rsp_valid), 32'd0);
    step();
`ifdef PCPI_TIMEOUT_EN
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_illegal", 32'(rsp_illegal), 32'd1);
    check("to_rsp_rd", rsp_rd, 32'd0);
    check("to_rsp_wr", 32'(rsp_wr), 32'd0);
    handshake("to");
`else
    check("to_off_rsp_valid", 32'(rsp_valid), 32'd0);
    check("to_off_pcpi_valid", 32'(pcpi_valid), 32'd1);
    check("to_off_rsp_illegal", 32'(rsp_illegal), 32'd0);
    pcpi_ready = 1'b1;
    pcpi_rd    = 32'd9;
    step();
    pcpi_ready = 1'b0;
    check("to_off_late_valid", 32'(rsp_valid), 32'd1);
    check("to_off_late_rd", rsp_rd, 32'd9);
    handshake("to_off");
`endif

    // Long pcpi_wait suppresses the timeout
    issue(32'h02B3_0333, 32'd3, 32'd4);
    pcpi_wait  = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen_valid |= rsp_valid;
    end
    check("wait_no_timeout", 32'(seen_valid), 32'd0);
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'hFFFF_FFFF;
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wait_rsp_rd", rsp_rd, 32'hFFFF_FFFF);
    check("wait_rsp_illegal", 32'(rsp_illegal), 32'd0);
    handshake("wait");

    // Ready in the same cycle the counter reaches 15
    issue(32'h02C3_0333, 32'd5, 32'd5);
    for (int i = 0; i < 15; i++) step();
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h1234_5678;
    step();
    pcpi_ready = 1'b0;
    check("prio_rsp_valid", 32'(rsp_valid), 32'd1);
    check("prio_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("prio_rsp_rd", rsp_rd, 32'h1234_5678);
    check("prio_rsp_wr", 32'(rsp_wr), 32'd0);
    handshake("prio");

    // Backpressure in RESP holds the response and blocks new requests
    issue(32'h02D3_0333, 32'd8, 32'd8);
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'h0000_A5A5;
    step();
    held_rd    = 32'h0000_A5A5;
    req_valid  = 1'b1;
    req_insn   = 32'h0253_0333;
    pcpi_rd    = 32'h0BAD_0BAD;
    pcpi_wr    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rd", rsp_rd, held_rd);
      check("bp_rsp_wr", 32'(rsp_wr), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    pcpi_ready = 1'b0;
    check("bp_insn_held", pcpi_insn, 32'h02D3_0333);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_after_hs_idle", 32'(req_ready), 32'd1);
    check("bp_not_same_cycle", 32'(pcpi_valid), 32'd0);
    step();
    req_valid = 1'b0;
    check("bp_second_accepted", 32'(pcpi_valid), 32'd1);
    check("bp_second_insn", pcpi_insn, 32'h0253_0333);
    pcpi_ready = 1'b1;
    pcpi_rd    = 32'd1;
    step();
    pcpi_ready = 1'b0;
    handshake("bp");

    // Reset in the third ISSUE cycle drops the request
    issue(32'h02E3_0333, 32'd2, 32'd2);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_pcpi_valid", 32'(pcpi_valid), 32'd0);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rr_req_ready", 32'(req_ready), 32'd1);
    check("rr_pcpi_insn", pcpi_insn, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_valid |= rsp_valid | pcpi_valid;
    end
    check("rr_no_response", 32'(seen_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpi_issue.md
PCPI_ISSUE -- requirements
Module: pcpi_issue

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, number of consecutive non-waiting ISSUE cycles before a request is declared illegal (legal range 2..255).
REQ-002 SHALL have ports, clock and reset first; clock is clk, reset is reset; one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core presents an instruction
- req_ready  out  1  block can accept a request
- req_insn  in  32  instruction word
- req_rs1, req_rs2  in  32 each  operands
- rsp_valid  out  1  response available
- rsp_ready  in  1  core accepts response
- rsp_wr  out  1  responder requested rd write
- rsp_rd  out  32  result
- rsp_illegal  out  1  no responder claimed the instruction
- pcpi_valid  out  1  PCPI request strobe
- pcpi_insn, pcpi_rs1, pcpi_rs2  out  32 each  PCPI request payload
- pcpi_wr  in  1  responder write flag
- pcpi_rd  in  32  responder result
- pcpi_wait  in  1  responder busy, suppresses timeout
- pcpi_ready  in  1  responder done, one-cycle pulse

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP; pcpi_valid=1 only in ISSUE; all are registered state decodes.
REQ-004 IDLE: on req_valid&&req_ready at edge N, SHALL latch insn/rs1/rs2 and enter ISSUE; pcpi_valid first high in cycle N+1.
REQ-005 pcpi_insn/rs1/rs2 SHALL stay constant from entry into ISSUE until the next accepted request.
REQ-006 ISSUE: timeout counter SHALL be 0 on entry; each cycle it clears if pcpi_wait=1, otherwise increments by 1 (8-bit, saturating).
REQ-007 ISSUE with pcpi_ready=1 SHALL capture rsp_wr=pcpi_wr, rsp_rd=pcpi_rd, rsp_illegal=0 and enter RESP; pcpi_valid low the next cycle.
REQ-008 ISSUE with pcpi_ready=0, pcpi_wait=0, counter==TIMEOUT_CYCLES-1 SHALL set rsp_illegal=1, rsp_wr=0, rsp_rd=0 and enter RESP.
REQ-009 pcpi_ready SHALL take priority over timeout in the same cycle.
REQ-010 Latency: pcpi_ready in cycle M gives rsp_valid in M+1; with no wait and no ready, rsp_illegal response appears in cycle N+1+TIMEOUT_CYCLES.
REQ-011 RESP: rsp_* SHALL be held stable until rsp_valid&&rsp_ready, then IDLE; no new request is accepted in that same cycle.
REQ-012 pcpi_ready/pcpi_wait/pcpi_wr/pcpi_rd SHALL be ignored in IDLE and RESP.

Reset
REQ-013 reset SHALL force IDLE at the next edge, from any state including mid-ISSUE; the in-flight request is dropped with no response.
REQ-014 Reset values SHALL be: req_ready=1 (IDLE), rsp_valid=0, pcpi_valid=0, rsp_wr=0, rsp_illegal=0, rsp_rd=0, pcpi_insn/rs1/rs2=0, counter=0.

Configuration
REQ-015 Macro PCPI_TIMEOUT_EN defined: REQ-006/008 timeout logic SHALL be present.
REQ-016 Macro undefined: the counter SHALL be absent, ISSUE SHALL wait indefinitely for pcpi_ready, and rsp_illegal SHALL be constant 0.

Structure
REQ-017 Package pcpi_pkg SHALL hold the FSM state enum, the PCPI opcode constants (OP 7'b0110011, MULDIV funct7 7'b0000001), and the default timeout constant.
REQ-018 The timeout counter SHALL be sub-module pcpi_timer (inputs clear/enable/wait, output expired), instantiated only under PCPI_TIMEOUT_EN.

Verification
REQ-019 Bench SHALL cover:
- MUL insn 0x02A30333, rs1=7, rs2=6, model asserts pcpi_wait 2 cycles after pcpi_valid, pcpi_ready+pcpi_wr with rd=42 after 5 cycles -> rsp_rd=42, rsp_wr=1, rsp_illegal=0, rsp_valid one cycle after pcpi_ready.
- No responder, accept at N -> rsp_valid with rsp_illegal=1, rsp_rd=0, rsp_wr=0 at N+17 (default; macro on).
- pcpi_wait held 40 cycles then pcpi_ready with rd=0xFFFFFFFF -> no timeout, rsp_rd=0xFFFFFFFF.
- pcpi_ready in the same cycle counter reaches 15 -> rsp_illegal=0, result taken.
- rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready=0, second req_valid not accepted until after handshake.
- reset pulsed in 3rd ISSUE cycle -> next cycle pcpi_valid=0, rsp_valid=0, req_ready=1; no response emitted.
